// File: rtl/water_dispenser_pkg.sv
// rtl/water_dispenser_pkg.sv - shared state encoding and constant helpers for the water dispenser
package water_dispenser_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DISPENSING = 2'd1,
    PAUSED     = 2'd2
  } state_t;

  // ceil(log2(value)); returns 0 for value <= 1
  function automatic int clog2(input longint unsigned value);
    longint unsigned span;
    int bits;
    span = 64'd1;
    bits = 0;
    while (span < value) begin
      span = span << 1;
      bits = bits + 1;
    end
    return bits;
  endfunction

  function automatic longint unsigned pow10(input int exponent);
    longint unsigned result;
    result = 64'd1;
    for (int i = 0; i < exponent; i++) result = result * 64'd10;
    return result;
  endfunction

endpackage

// File: rtl/button.sv
// rtl/button.sv - synchroniser and release-edge detector for a raw active-low button
module button (
  input  logic clock_i,
  input  logic reset_i,
  input  logic button_n_i,
  output logic release_o
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  assign sync_d    = {sync_q[1:0], button_n_i};
  assign release_o = sync_q[1] & ~sync_q[2];

  // Shift the raw level through; reset to the released level so no event fires after reset
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) sync_q <= 3'b111;
    else         sync_q <= sync_d;
  end

endmodule

// File: rtl/ml_tick_timer.sv
// rtl/ml_tick_timer.sv - per-millilitre tick pulse and pause-blink generator
module ml_tick_timer
  import water_dispenser_pkg::*;
#(
  parameter int  CYCLES_PER_ML     = 5,
  parameter int  BLINK_HALF_CYCLES = 1,
  localparam int TICK_W  = (CYCLES_PER_ML > 1) ? clog2(64'(CYCLES_PER_ML)) : 1,
  localparam int BLINK_W = (BLINK_HALF_CYCLES > 1) ? clog2(64'(BLINK_HALF_CYCLES)) : 1
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o,
  output logic blink_o
);

  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;

  assign tick_o  = enable_i && (tick_cnt_q == TICK_W'(CYCLES_PER_ML - 1));
  assign blink_o = blink_q;

  // Tick counter only advances while enabled so a pause holds the partial millilitre;
  // blink restarts lit whenever cleared so a pause is visible immediately
  always_comb begin
    tick_cnt_d  = tick_cnt_q;
    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_d     = blink_q;
    if (clear_i) begin
      tick_cnt_d  = '0;
      blink_cnt_d = '0;
      blink_d     = 1'b1;
    end else begin
      if (tick_o)        tick_cnt_d = '0;
      else if (enable_i) tick_cnt_d = tick_cnt_q + 1'b1;
      if (blink_cnt_q == BLINK_W'(BLINK_HALF_CYCLES - 1)) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end
    end
  end

  // Counter and blink registers
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      tick_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

endmodule

// File: rtl/seven_segment_display.sv
// rtl/seven_segment_display.sv - BCD digit to active-high gfedcba segment byte, dp off
module seven_segment_display (
  input  logic [3:0] digit_i,
  output logic [7:0] segments_o
);

  // Segment lookup; non-decimal codes blank the digit
  always_comb begin
    segments_o = 8'h00;
    case (digit_i)
      4'd0: segments_o = 8'h3F;
      4'd1: segments_o = 8'h06;
      4'd2: segments_o = 8'h5B;
      4'd3: segments_o = 8'h4F;
      4'd4: segments_o = 8'h66;
      4'd5: segments_o = 8'h6D;
      4'd6: segments_o = 8'h7D;
      4'd7: segments_o = 8'h07;
      4'd8: segments_o = 8'h7F;
      4'd9: segments_o = 8'h6F;
      default: segments_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/multi_outlet_water_dispenser.sv
// rtl/multi_outlet_water_dispenser.sv - keypad volume entry, multi-outlet timed relay dispenser
module multi_outlet_water_dispenser
  import water_dispenser_pkg::*;
#(
  parameter int  CHANNEL_COUNT   = 2,
  parameter int  DIGIT_COUNT     = 4,
  parameter int  SWITCH_COUNT    = 10,
  parameter int  CLOCK_PERIOD_NS = 20,
  parameter int  NS_PER_ML       = 1000000,
  localparam int VOL_W = clog2(pow10(DIGIT_COUNT)),
  localparam int SEL_W = (CHANNEL_COUNT > 1) ? clog2(64'(CHANNEL_COUNT)) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [SWITCH_COUNT-1:0]  switches,
  input  logic                     button_add,
  input  logic                     button_ok,
  input  logic                     button_cancel,
  input  logic                     button_channel,
  output logic [VOL_W-1:0]         amount_in_ml,
  output logic [VOL_W-1:0]         remaining_in_ml,
  output logic [SEL_W-1:0]         selected_channel,
  output logic [8*DIGIT_COUNT-1:0] displays,
  output logic                     led,
  output logic [CHANNEL_COUNT-1:0] relay
);

  localparam int CYCLES_PER_ML     = NS_PER_ML / CLOCK_PERIOD_NS;
  localparam int BLINK_RAW         = 250_000_000 / CLOCK_PERIOD_NS;
  localparam int BLINK_HALF_CYCLES = (BLINK_RAW > 1) ? BLINK_RAW : 1;
  localparam int DIG_W             = clog2(64'(DIGIT_COUNT + 1));

  logic ev_add, ev_ok, ev_cancel, ev_channel;
  logic tick, blink;

  state_t                   state_q, state_d;
  logic [VOL_W-1:0]         amount_q, amount_d, remaining_q, remaining_d;
  logic [SEL_W-1:0]         sel_q, sel_d;
  logic [DIG_W-1:0]         digits_q, digits_d;
  logic [CHANNEL_COUNT-1:0] relay_q, relay_d;
  logic                     led_q, led_d;

  button u_btn_add     (.clock_i(clock), .reset_i(reset), .button_n_i(button_add),     .release_o(ev_add));
  button u_btn_ok      (.clock_i(clock), .reset_i(reset), .button_n_i(button_ok),      .release_o(ev_ok));
  button u_btn_cancel  (.clock_i(clock), .reset_i(reset), .button_n_i(button_cancel),  .release_o(ev_cancel));
  button u_btn_channel (.clock_i(clock), .reset_i(reset), .button_n_i(button_channel), .release_o(ev_channel));

  ml_tick_timer #(
    .CYCLES_PER_ML    (CYCLES_PER_ML),
    .BLINK_HALF_CYCLES(BLINK_HALF_CYCLES)
  ) u_timer (
    .clock_i (clock),
    .reset_i (reset),
    .clear_i (state_q == IDLE),
    .enable_i(state_q == DISPENSING),
    .tick_o  (tick),
    .blink_o (blink)
  );

  logic                 sw_any;
  logic [3:0]           sw_digit;
  logic [VOL_W+3:0]     appended;

  // Lowest-index set switch selects the digit
  always_comb begin
    sw_any   = 1'b0;
    sw_digit = '0;
    for (int i = SWITCH_COUNT - 1; i >= 0; i--) begin
      if (switches[i]) begin
        sw_any   = 1'b1;
        sw_digit = 4'(i);
      end
    end
  end

  assign appended = {4'd0, amount_q} * (VOL_W + 4)'(10) + {{VOL_W{1'b0}}, sw_digit};

  // Next state; events are already prioritised cancel > ok > channel > add by the if-chains
  always_comb begin
    state_d     = state_q;
    amount_d    = amount_q;
    remaining_d = remaining_q;
    sel_d       = sel_q;
    digits_d    = digits_q;
    case (state_q)
      IDLE: begin
        if (ev_cancel) begin
          amount_d = '0;
          digits_d = '0;
        end else if (ev_ok) begin
          if (amount_q != '0) begin
            remaining_d = amount_q;
            state_d     = DISPENSING;
          end
        end else if (ev_channel) begin
          sel_d = (sel_q == SEL_W'(CHANNEL_COUNT - 1)) ? '0 : sel_q + 1'b1;
        end else if (ev_add && sw_any && (digits_q < DIG_W'(DIGIT_COUNT))) begin
          amount_d = appended[VOL_W-1:0];
          if (appended != '0) digits_d = digits_q + 1'b1;
        end
      end
      DISPENSING: begin
        if (ev_cancel || (remaining_q == '0)) begin
          state_d     = IDLE;
          amount_d    = '0;
          remaining_d = '0;
          digits_d    = '0;
        end else begin
          if (tick)  remaining_d = remaining_q - 1'b1;
          if (ev_ok) state_d = PAUSED;
        end
      end
      PAUSED: begin
        if (ev_cancel) begin
          state_d     = IDLE;
          amount_d    = '0;
          remaining_d = '0;
          digits_d    = '0;
        end else if (ev_ok) begin
          state_d = DISPENSING;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Valve open only while volume remains, so the terminal cycle does not over-pour
  always_comb begin
    relay_d = '1;
    if ((state_q == DISPENSING) && (remaining_q != '0)) relay_d[sel_q] = 1'b0;
    led_d = (state_q == DISPENSING) || ((state_q == PAUSED) && blink);
  end

  // Control and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      amount_q    <= '0;
      remaining_q <= '0;
      sel_q       <= '0;
      digits_q    <= '0;
      relay_q     <= '1;
      led_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      amount_q    <= amount_d;
      remaining_q <= remaining_d;
      sel_q       <= sel_d;
      digits_q    <= digits_d;
      relay_q     <= relay_d;
      led_q       <= led_d;
    end
  end

  assign amount_in_ml     = amount_q;
  assign remaining_in_ml  = remaining_q;
  assign selected_channel = sel_q;
  assign relay            = relay_q;
  assign led              = led_q;

  logic [VOL_W-1:0] disp_value;
  assign disp_value = (state_q == IDLE) ? amount_q : remaining_q;

  for (genvar k = 0; k < DIGIT_COUNT; k++) begin : g_digit
    logic [3:0] digit;
    assign digit = 4'((disp_value / VOL_W'(pow10(k))) % VOL_W'(10));
    seven_segment_display u_seg (.digit_i(digit), .segments_o(displays[8*k +: 8]));
  end

endmodule

// File: tb/tb_multi_outlet_water_dispenser.sv
// tb/tb_multi_outlet_water_dispenser.sv - directed bench with a volume-level reference model
module tb_multi_outlet_water_dispenser;

  localparam int CPM = 5;
  localparam int B_ADD = 0, B_OK = 1, B_CANCEL = 2, B_CHAN = 3;
  localparam int S_IDLE = 0, S_DISP = 1, S_PAUSE = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  switches = '0;
  logic        button_add = 1'b1, button_ok = 1'b1, button_cancel = 1'b1, button_channel = 1'b1;
  logic [13:0] amount_in_ml, remaining_in_ml;
  logic [0:0]  selected_channel;
  logic [31:0] displays;
  logic        led;
  logic [1:0]  relay;

  multi_outlet_water_dispenser #(
    .CHANNEL_COUNT(2), .DIGIT_COUNT(4), .SWITCH_COUNT(10),
    .CLOCK_PERIOD_NS(20), .NS_PER_ML(100)
  ) dut (
    .clock(clock), .reset(reset), .switches(switches),
    .button_add(button_add), .button_ok(button_ok),
    .button_cancel(button_cancel), .button_channel(button_channel),
    .amount_in_ml(amount_in_ml), .remaining_in_ml(remaining_in_ml),
    .selected_channel(selected_channel), .displays(displays),
    .led(led), .relay(relay)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int low_cnt  = 0;
  bit run_cmp  = 0;
  int due [4];

  // Model: volume-level view of the dispenser
  int m_state, m_amount, m_digits, m_sel, m_target, m_elapsed;
  logic [1:0] m_relay;
  logic       m_led;

  function automatic int m_rem();
    return m_target - m_elapsed / CPM;
  endfunction

  function automatic logic [7:0] seg(input int d);
    case (d)
      0: return 8'h3F; 1: return 8'h06; 2: return 8'h5B; 3: return 8'h4F; 4: return 8'h66;
      5: return 8'h6D; 6: return 8'h7D; 7: return 8'h07; 8: return 8'h7F; default: return 8'h6F;
    endcase
  endfunction

  function automatic logic [31:0] exp_disp();
    logic [31:0] r;
    int v, p;
    v = (m_state == S_IDLE) ? m_amount : m_rem();
    p = 1;
    for (int k = 0; k < 4; k++) begin
      r[8*k +: 8] = seg((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic model_clear();
    m_state = S_IDLE; m_amount = 0; m_digits = 0; m_target = 0; m_elapsed = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_sel = 0; m_relay = 2'b11; m_led = 1'b0;
    for (int b = 0; b < 4; b++) due[b] = -1;
  endtask

  task automatic model_step();
    bit ea, eo, ec, ech;
    int sw;
    ea = (due[B_ADD] == cyc); eo = (due[B_OK] == cyc);
    ec = (due[B_CANCEL] == cyc); ech = (due[B_CHAN] == cyc);
    m_relay = 2'b11;
    if (m_state == S_DISP && m_rem() > 0) m_relay[m_sel] = 1'b0;
    m_led = (m_state == S_DISP) || (m_state == S_PAUSE);
    sw = -1;
    for (int i = 9; i >= 0; i--) if (switches[i]) sw = i;
    case (m_state)
      S_IDLE: begin
        if (ec) model_clear();
        else if (eo) begin
          if (m_amount > 0) begin m_target = m_amount; m_elapsed = 0; m_state = S_DISP; end
        end else if (ech) m_sel = (m_sel + 1) % 2;
        else if (ea && sw >= 0 && m_digits < 4) begin
          m_amount = m_amount * 10 + sw;
          if (m_amount != 0) m_digits++;
        end
      end
      S_DISP: begin
        if (ec || m_rem() == 0) model_clear();
        else begin
          m_elapsed++;
          if (eo) m_state = S_PAUSE;
        end
      end
      default: begin
        if (ec) model_clear();
        else if (eo) m_state = S_DISP;
      end
    endcase
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock);
      cyc++;
      if (reset) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (!reset && run_cmp) begin
        if (relay != 2'b11) low_cnt++;
        chk("amount", 64'(amount_in_ml), 64'(m_amount));
        chk("remaining", 64'(remaining_in_ml), 64'(m_rem()));
        chk("sel", 64'(selected_channel), 64'(m_sel));
        chk("relay", 64'(relay), 64'(m_relay));
        chk("led", 64'(led), 64'(m_led));
        chk("displays", 64'(displays), 64'(exp_disp()));
      end
    end
  end

  task automatic tick_n(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic btn_drive(input int b, input logic v);
    case (b)
      B_ADD:    button_add = v;
      B_OK:     button_ok = v;
      B_CANCEL: button_cancel = v;
      default:  button_channel = v;
    endcase
  endtask

  task automatic press(input logic [3:0] mask);
    for (int b = 0; b < 4; b++) if (mask[b]) btn_drive(b, 1'b0);
    tick_n(2);
    for (int b = 0; b < 4; b++) if (mask[b]) begin btn_drive(b, 1'b1); due[b] = cyc + 3; end
    tick_n(4);
  endtask

  task automatic add_digit(input int d);
    switches = 10'(1 << d);
    press(4'b0001);
  endtask

  int d0;

  initial begin
    tick_n(3);
    reset = 1'b0;
    tick_n(1);
    chk("reset amount", 64'(amount_in_ml), 0);
    chk("reset relay", 64'(relay), 64'h3);
    chk("reset led", 64'(led), 0);
    chk("reset sel", 64'(selected_channel), 0);
    chk("reset displays", 64'(displays), 64'h3F3F3F3F);
    run_cmp = 1;

    // Entry: no switch ignored, then 3,0,7 and digit limit
    switches = '0; press(4'b0001);
    chk("add no switch", 64'(amount_in_ml), 0);
    add_digit(3); chk("amount 3", 64'(amount_in_ml), 3);
    add_digit(0); chk("amount 30", 64'(amount_in_ml), 30);
    add_digit(7); chk("amount 307", 64'(amount_in_ml), 307);
    chk("display 0307", 64'(displays), 64'h3F4F3F07);
    for (int i = 0; i < 5; i++) add_digit(1);
    chk("amount 4 digits", 64'(amount_in_ml), 3071);
    press(4'b0100);
    chk("cancel clears", 64'(amount_in_ml), 0);

    // Leading zeros free, lowest switch wins
    add_digit(0); add_digit(0);
    chk("leading zeros", 64'(amount_in_ml), 0);
    switches = 10'b0100100000; press(4'b0001);
    chk("lowest switch", 64'(amount_in_ml), 5);
    add_digit(1); add_digit(2); add_digit(3);
    chk("amount 5123", 64'(amount_in_ml), 5123);
    add_digit(9);
    chk("full ignored", 64'(amount_in_ml), 5123);
    press(4'b0100);

    // 3 mL on outlet 1
    press(4'b1000);
    chk("sel 1", 64'(selected_channel), 1);
    add_digit(3);
    low_cnt = 0;
    press(4'b0010);
    chk("relay outlet1", 64'(relay), 64'h1);
    chk("remaining 3", 64'(remaining_in_ml), 3);
    tick_n(25);
    chk("relay low 15", 64'(low_cnt), 15);
    chk("done relay", 64'(relay), 64'h3);
    chk("done amount", 64'(amount_in_ml), 0);
    press(4'b1000);
    chk("sel wrap", 64'(selected_channel), 0);

    // 4 mL with a pause after 7 cycles
    add_digit(4);
    low_cnt = 0;
    btn_drive(B_OK, 1'b0); tick_n(2);
    btn_drive(B_OK, 1'b1); due[B_OK] = cyc + 3; d0 = cyc + 3;
    tick_n(2); btn_drive(B_OK, 1'b0);
    while (cyc < d0 + 4) @(negedge clock);
    btn_drive(B_OK, 1'b1); due[B_OK] = cyc + 3;
    tick_n(100);
    chk("paused remaining", 64'(remaining_in_ml), 3);
    chk("paused relay", 64'(relay), 64'h3);
    chk("paused led", 64'(led), 1);
    press(4'b0010);
    tick_n(30);
    chk("total low 20", 64'(low_cnt), 20);
    chk("after pause amount", 64'(amount_in_ml), 0);

    // Cancel beats ok; channel/add ignored while dispensing
    add_digit(5);
    press(4'b0010);
    press(4'b1000);
    add_digit(2);
    chk("disp sel held", 64'(selected_channel), 0);
    chk("disp amount held", 64'(amount_in_ml), 5);
    press(4'b0110);
    chk("cancel wins led", 64'(led), 0);
    chk("cancel wins relay", 64'(relay), 64'h3);
    chk("cancel wins display", 64'(displays), 64'h3F3F3F3F);
    press(4'b0010);
    tick_n(3);
    chk("ok zero relay", 64'(relay), 64'h3);
    chk("ok zero led", 64'(led), 0);

    // Async reset mid-dispense
    press(4'b1000);
    add_digit(9);
    press(4'b0010);
    tick_n(3);
    chk("pre-reset relay", 64'(relay), 64'h1);
    @(posedge clock);
    #2;
    run_cmp = 0;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async relay", 64'(relay), 64'h3);
    chk("async amount", 64'(amount_in_ml), 0);
    chk("async sel", 64'(selected_channel), 0);
    chk("async led", 64'(led), 0);
    tick_n(2);
    reset = 1'b0;
    run_cmp = 1;
    tick_n(5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
